btb_update_ctrl: RTL and testbench
==================================

# btb_update_ctrl

Controller that owns the write port of the branch target buffer. It tracks fetched PCs and BTB hit status through the D and E stages under stall and flush. It queues BTB allocations for resolved taken branches and jumps that missed in fetch, and runs an invalidation sweep over all entries on request. It sits between the fetch/execute pipeline control and the BTB storage array, and gates BTB lookups while the array is being rewritten.

## Interface
Parameters:
- NUM_BTB_ENTRIES, 32, BTB entries; power of two, ≥ 2; LOG2 = $clog2(NUM_BTB_ENTRIES)
- FIFO_DEPTH, 2, pending-update queue depth; power of two, ≥ 2

Ports:
- clk  in  1  clock
- reset_i  in  1  reset, asynchronous, active-high
- stall_i  in  1  freeze F/D/E tracking registers
- flush_de_i  in  1  kill instructions in D and E (mispredict)
- pc_f_i  in  32  fetch PC
- hit_f_i  in  1  BTB hit for pc_f_i this cycle
- j_e_i, b_e_i  in  1 each  E-stage instruction is jump / branch
- taken_e_i  in  1  E-stage branch resolved taken
- target_e_i  in  32  resolved target
- invalidate_i  in  1  start full BTB invalidation
- wr_en_o  out  1  BTB write strobe
- wr_idx_o  out  LOG2  entry index
- wr_tag_o  out  30-LOG2  tag, pc[31:LOG2+2]
- wr_target_o  out  32  target
- wr_j_o, wr_b_o  out  1 each  entry type bits
- lookup_en_o  out  1  BTB predictions permitted
- busy_o  out  1  sweep in progress
- drop_o  out  1  one-cycle pulse: update discarded

## Operation
- Tracking: valid_d/pc_d/hit_d and valid_e/pc_e/hit_e. When !stall_i: D←{1,pc_f_i,hit_f_i}, E←D. flush_de_i clears valid_d and valid_e, and overrides stall.
- Update request `req` = valid_e & !stall_i & !flush_de_i & !hit_e & (j_e_i | (b_e_i & taken_e_i)). At most one request is made per instruction.
- Queued entry: {idx=pc_e[LOG2+1:2], tag=pc_e[31:LOG2+2], target_e_i, j_e_i, b_e_i}.
- FSM states:
  - IDLE
    - invalidate_i → SWEEP; counter := 0; FIFO cleared.
    - Otherwise a non-empty FIFO drives wr_en_o=1 with the head fields, and the head pops that cycle.
  - SWEEP
    - wr_en_o=1, wr_idx_o=counter, tag/target/j/b=0; counter increments each cycle.
    - Counter at NUM_BTB_ENTRIES-1 → IDLE.
    - invalidate_i restarts counter at 0.
- Push rules:
  - req in IDLE is pushed if not full, or if full and popping this cycle.
  - Otherwise the request is dropped with drop_o=1.
  - req during SWEEP, or in the same cycle as invalidate_i, is dropped and pulses drop_o.
- lookup_en_o = (state==IDLE); busy_o = (state==SWEEP).
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter width is $clog2(FIFO_DEPTH)+1.

## Timing
- Reset values: state IDLE, FIFO empty, valid_d=valid_e=0, counter 0. wr_en_o=0, all wr_* fields 0, drop_o=0, busy_o=0, lookup_en_o=1.
- Update latency: req at cycle t with FIFO empty → wr_en_o at t+1. Each queued entry ahead adds 1 cycle.
- Sweep: invalidate_i at t → indices 0..N-1 are written at t+1..t+N. busy_o is high t+1..t+N; IDLE and lookup_en_o=1 at t+N+1.
- Reset asserted mid-sweep or with FIFO non-empty: everything returns to reset values immediately. No partial write completes after reset deasserts.
- wr_* outputs are combinational from the state, counter and FIFO head. There is no input-to-output combinational path.

## Structure
- Package btb_pkg:
  - btb_log2 constant function
  - btb_upd_t struct {idx, tag, target, j, b}
  - state enum {IDLE, SWEEP}
  - the tag-width expression, shared with the BTB storage.
- Sub-module btb_upd_fifo: synchronous FIFO of btb_upd_t, parameter FIFO_DEPTH. Ports push/pop/clear/full/empty/head. Asynchronous reset.
- FSM, counter and tracking registers live in the top module.

## Test plan
- Jump miss: pc_f_i=0x0000_0040, hit_f_i=0, no stall; at E j_e_i=1, target_e_i=0x100 → 1 cycle later wr_en_o=1, wr_idx_o=0x10, wr_tag_o=0, wr_j_o=1.
- Taken-branch hit vs not-taken: hit_e=1 with taken → no write. Branch miss with taken_e_i=0 → no write. Branch miss with taken_e_i=1 → one write.
- Stall/flush: hold stall_i 3 cycles with a miss jump in E → exactly one write after release. flush_de_i in the cycle it reaches E → no write.
- FIFO full: FIFO_DEPTH=2, three back-to-back miss jumps, with invalidate_i forcing a held head → the third request pulses drop_o, and the writes that do occur are in order.
- Sweep, N=32: invalidate_i at t → 32 consecutive writes, idx 0..31, all fields zero. lookup_en_o low t+1..t+32. A req at t+5 pulses drop_o. invalidate_i at t+10 restarts at idx 0.
- Reset at t+7 of a sweep → wr_en_o=0, lookup_en_o=1, FIFO empty on the next cycle.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and sizing helpers for the BTB write-port controller and BTB storage.
package btb_pkg;

  localparam int unsigned BTB_PC_W    = 32;
  // Idx and tag fields are sized for the widest legal layout; users slice the low bits.
  localparam int unsigned BTB_FIELD_W = 30;

  function automatic int unsigned btb_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Tag covers pc[31:LOG2+2]; shared with the BTB storage array.
  function automatic int unsigned btb_tag_w(input int unsigned n_entries);
    return 30 - btb_log2(n_entries);
  endfunction

  typedef struct packed {
    logic [BTB_FIELD_W-1:0] idx;
    logic [BTB_FIELD_W-1:0] tag;
    logic [BTB_PC_W-1:0]    target;
    logic                   j;
    logic                   b;
  } btb_upd_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } btb_state_e;

endpackage

// File: rtl/btb_upd_fifo.sv
// Pending BTB update queue: synchronous FIFO with clear and asynchronous reset.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset_i,
  input  logic     push_i,
  input  logic     pop_i,
  input  logic     clear_i,
  input  btb_upd_t data_i,
  output logic     full_o,
  output logic     empty_o,
  output btb_upd_t head_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  btb_upd_t         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_q, wr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_q];

  // Pointer and occupancy bookkeeping; clear empties the queue in one cycle.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed while occupancy is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write-port owner: D/E hit tracking, miss-allocation queue and invalidation sweep.
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int unsigned NUM_BTB_ENTRIES = 32,
  parameter int unsigned FIFO_DEPTH      = 2
) (
  input  logic                                  clk,
  input  logic                                  reset_i,
  input  logic                                  stall_i,
  input  logic                                  flush_de_i,
  input  logic [31:0]                           pc_f_i,
  input  logic                                  hit_f_i,
  input  logic                                  j_e_i,
  input  logic                                  b_e_i,
  input  logic                                  taken_e_i,
  input  logic [31:0]                           target_e_i,
  input  logic                                  invalidate_i,
  output logic                                  wr_en_o,
  output logic [btb_log2(NUM_BTB_ENTRIES)-1:0]  wr_idx_o,
  output logic [btb_tag_w(NUM_BTB_ENTRIES)-1:0] wr_tag_o,
  output logic [31:0]                           wr_target_o,
  output logic                                  wr_j_o,
  output logic                                  wr_b_o,
  output logic                                  lookup_en_o,
  output logic                                  busy_o,
  output logic                                  drop_o
);

  localparam int unsigned     LOG2     = btb_log2(NUM_BTB_ENTRIES);
  localparam int unsigned     TAG_W    = btb_tag_w(NUM_BTB_ENTRIES);
  localparam logic [LOG2-1:0] LAST_IDX = LOG2'(NUM_BTB_ENTRIES - 1);

  btb_state_e      state_q, state_d;
  logic [LOG2-1:0] cnt_q, cnt_d;
  logic            drop_q, drop_d;
  logic            valid_d_q, hit_d_q, valid_e_q, hit_e_q;
  logic [31:0]     pc_d_q, pc_e_q;
  logic            req;
  logic            fifo_push, fifo_pop, fifo_clear, fifo_full, fifo_empty;
  btb_upd_t        new_entry, fifo_head;
  logic            unused_bits;

  assign unused_bits = ^{pc_e_q[1:0], fifo_head.idx[BTB_FIELD_W-1:LOG2],
                         fifo_head.tag[BTB_FIELD_W-1:TAG_W]};

  // F->D->E tracking; flush kills D and E even while stalled.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      valid_d_q <= 1'b0;
      pc_d_q    <= '0;
      hit_d_q   <= 1'b0;
      valid_e_q <= 1'b0;
      pc_e_q    <= '0;
      hit_e_q   <= 1'b0;
    end else if (flush_de_i) begin
      valid_d_q <= 1'b0;
      valid_e_q <= 1'b0;
    end else if (!stall_i) begin
      valid_d_q <= 1'b1;
      pc_d_q    <= pc_f_i;
      hit_d_q   <= hit_f_i;
      valid_e_q <= valid_d_q;
      pc_e_q    <= pc_d_q;
      hit_e_q   <= hit_d_q;
    end
  end

  assign req = valid_e_q & ~stall_i & ~flush_de_i & ~hit_e_q & (j_e_i | (b_e_i & taken_e_i));

  // Build the queue entry for the instruction currently in E.
  always_comb begin
    new_entry                  = '0;
    new_entry.idx[LOG2-1:0]    = pc_e_q[LOG2+1:2];
    new_entry.tag[TAG_W-1:0]   = pc_e_q[31:LOG2+2];
    new_entry.target           = target_e_i;
    new_entry.j                = j_e_i;
    new_entry.b                = b_e_i;
  end

  btb_upd_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .clear_i (fifo_clear),
    .data_i  (new_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // State, sweep counter and registered drop pulse.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  // Next state, queue control and drop decision.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drop_d     = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_clear = 1'b0;
    case (state_q)
      IDLE: begin
        fifo_pop = ~fifo_empty;
        if (invalidate_i) begin
          state_d    = SWEEP;
          cnt_d      = '0;
          fifo_clear = 1'b1;
        end
        if (req) begin
          if (invalidate_i || (fifo_full && !fifo_pop)) drop_d = 1'b1;
          else fifo_push = 1'b1;
        end
      end
      SWEEP: begin
        drop_d = req;
        if (invalidate_i) begin
          cnt_d      = '0;
          fifo_clear = 1'b1;
        end else if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write port driven only from registered state, counter and queue head.
  always_comb begin
    wr_en_o     = 1'b0;
    wr_idx_o    = '0;
    wr_tag_o    = '0;
    wr_target_o = '0;
    wr_j_o      = 1'b0;
    wr_b_o      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          wr_en_o     = 1'b1;
          wr_idx_o    = fifo_head.idx[LOG2-1:0];
          wr_tag_o    = fifo_head.tag[TAG_W-1:0];
          wr_target_o = fifo_head.target;
          wr_j_o      = fifo_head.j;
          wr_b_o      = fifo_head.b;
        end
      end
      SWEEP: begin
        wr_en_o  = 1'b1;
        wr_idx_o = cnt_q;
      end
      default: ;
    endcase
  end

  assign lookup_en_o = (state_q == IDLE);
  assign busy_o      = (state_q == SWEEP);
  assign drop_o      = drop_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl (NUM_BTB_ENTRIES=32, FIFO_DEPTH=2).
module tb_btb_update_ctrl;

  logic        clk = 1'b0;
  logic        reset_i, stall_i, flush_de_i, hit_f_i, j_e_i, b_e_i, taken_e_i, invalidate_i;
  logic [31:0] pc_f_i, target_e_i;
  logic        wr_en_o, wr_j_o, wr_b_o, lookup_en_o, busy_o, drop_o;
  logic [4:0]  wr_idx_o;
  logic [24:0] wr_tag_o;
  logic [31:0] wr_target_o;

  btb_update_ctrl #(
    .NUM_BTB_ENTRIES(32),
    .FIFO_DEPTH     (2)
  ) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .stall_i      (stall_i),
    .flush_de_i   (flush_de_i),
    .pc_f_i       (pc_f_i),
    .hit_f_i      (hit_f_i),
    .j_e_i        (j_e_i),
    .b_e_i        (b_e_i),
    .taken_e_i    (taken_e_i),
    .target_e_i   (target_e_i),
    .invalidate_i (invalidate_i),
    .wr_en_o      (wr_en_o),
    .wr_idx_o     (wr_idx_o),
    .wr_tag_o     (wr_tag_o),
    .wr_target_o  (wr_target_o),
    .wr_j_o       (wr_j_o),
    .wr_b_o       (wr_b_o),
    .lookup_en_o  (lookup_en_o),
    .busy_o       (busy_o),
    .drop_o       (drop_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [4:0]  idx;
    logic [24:0] tag;
    logic [31:0] tgt;
    logic        j;
    logic        b;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned exp_drop_q[$];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic void push_wr(input int unsigned c, input logic [31:0] pc, input logic [31:0] tgt,
                                  input logic j, input logic b);
    wr_t e;
    e.cyc = c;
    e.idx = pc[6:2];
    e.tag = pc[31:7];
    e.tgt = tgt;
    e.j   = j;
    e.b   = b;
    exp_q.push_back(e);
  endfunction

  function automatic void push_sweep(input int unsigned c, input int unsigned idx);
    wr_t e;
    e     = '0;
    e.cyc = c;
    e.idx = 5'(idx);
    exp_q.push_back(e);
  endfunction

  // Monitor: every write and drop pulse must match the head of its expectation queue.
  always @(negedge clk) begin
    wr_t g, e;
    if (wr_en_o) begin
      if (exp_q.size() == 0) check("unexpected_write", 128'(wr_en_o), 128'(0));
      else begin
        e = exp_q.pop_front();
        g = {32'(cyc), wr_idx_o, wr_tag_o, wr_target_o, wr_j_o, wr_b_o};
        check("write", 128'(g), 128'(e));
      end
    end
    if (drop_o) begin
      if (exp_drop_q.size() == 0) check("unexpected_drop", 128'(drop_o), 128'(0));
      else check("drop_cycle", 128'(cyc), 128'(exp_drop_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    pc_f_i  = 32'hFFFF_FFF0;
    hit_f_i = 1'b1;
  endtask

  // Fetch pc, let it reach E two cycles later and present its resolution there.
  task automatic issue(input logic [31:0] pc, input logic hit, input logic j, input logic b,
                       input logic tk, input logic [31:0] tgt, input bit expect_wr);
    pc_f_i  = pc;
    hit_f_i = hit;
    step();
    idle_in();
    step();
    j_e_i = j; b_e_i = b; taken_e_i = tk; target_e_i = tgt;
    if (expect_wr) push_wr(cyc + 1, pc, tgt, j, b);
    step();
    j_e_i = 1'b0; b_e_i = 1'b0; taken_e_i = 1'b0; target_e_i = '0;
    step();
  endtask

  initial begin
    int unsigned t;
    reset_i = 1'b1; stall_i = 1'b0; flush_de_i = 1'b0; invalidate_i = 1'b0;
    j_e_i = 1'b0; b_e_i = 1'b0; taken_e_i = 1'b0; target_e_i = '0;
    idle_in();
    repeat (2) step();
    check("reset_outputs",
          128'({wr_en_o, wr_idx_o, wr_tag_o, wr_target_o, wr_j_o, wr_b_o, drop_o, busy_o, lookup_en_o}),
          128'({1'b0, 5'd0, 25'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
    reset_i = 1'b0;
    repeat (2) step();

    // Directed single-instruction cases.
    issue(32'h0000_0040, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 1'b1);  // jump miss: idx 0x10, tag 0
    issue(32'h0000_0080, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b0);  // taken branch, hit: no write
    issue(32'h0000_0084, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0204, 1'b0);  // not-taken branch miss
    issue(32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b1, 32'hCAFE_0000, 1'b1);  // taken branch miss
    issue(32'h0000_00C0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0300, 1'b0);  // jump hit

    // Stall three cycles with a miss jump in E: one write after release.
    pc_f_i = 32'h0000_0400; hit_f_i = 1'b0; step();
    idle_in(); step();
    j_e_i = 1'b1; target_e_i = 32'h0000_0800; stall_i = 1'b1;
    repeat (3) step();
    stall_i = 1'b0;
    push_wr(cyc + 1, 32'h0000_0400, 32'h0000_0800, 1'b1, 1'b0);
    step();
    j_e_i = 1'b0; target_e_i = '0;
    repeat (2) step();

    // Flush (together with stall) as the jump reaches E: no write.
    pc_f_i = 32'h0000_0500; hit_f_i = 1'b0; step();
    idle_in(); step();
    j_e_i = 1'b1; target_e_i = 32'h0000_0900; flush_de_i = 1'b1; stall_i = 1'b1; step();
    flush_de_i = 1'b0; stall_i = 1'b0; step();
    j_e_i = 1'b0; target_e_i = '0;
    repeat (2) step();

    // Three back-to-back miss jumps; invalidate with the third drops it.
    t = cyc;
    push_wr(t + 3, 32'h0000_1000, 32'h0000_2002, 1'b1, 1'b0);
    push_wr(t + 4, 32'h0000_1004, 32'h0000_2003, 1'b1, 1'b0);
    exp_drop_q.push_back(t + 5);
    for (int unsigned i = 0; i < 32; i++) push_sweep(t + 5 + i, i);
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin pc_f_i = 32'h0000_1000 + 32'(4 * k); hit_f_i = 1'b0; end
      else idle_in();
      j_e_i        = (k >= 2);
      target_e_i   = 32'h0000_2000 + 32'(k);
      invalidate_i = (k == 4);
      step();
    end
    j_e_i = 1'b0; target_e_i = '0; invalidate_i = 1'b0;
    while (cyc < t + 40) step();
    check("idle_after_sweep", 128'({lookup_en_o, busy_o}), 128'(2'b10));

    // Sweep with a dropped request at t+5 and a restart at t+10.
    t = cyc;
    for (int unsigned i = 0; i < 10; i++) push_sweep(t + 1 + i, i);
    for (int unsigned i = 0; i < 32; i++) push_sweep(t + 11 + i, i);
    exp_drop_q.push_back(t + 6);
    invalidate_i = 1'b1;
    step();
    for (int k = 1; k <= 43; k++) begin
      if (k == 3) begin pc_f_i = 32'h0000_0200; hit_f_i = 1'b0; end
      else idle_in();
      j_e_i        = (k == 5);
      target_e_i   = (k == 5) ? 32'h0000_0300 : 32'h0;
      invalidate_i = (k == 10);
      if (k <= 42) check("sweep_status", 128'({lookup_en_o, busy_o}), 128'(2'b01));
      else         check("sweep_end_status", 128'({lookup_en_o, busy_o}), 128'(2'b10));
      step();
    end
    j_e_i = 1'b0; target_e_i = '0; invalidate_i = 1'b0;
    repeat (2) step();

    // Reset in cycle t+7 of a sweep: writes idx 0..5 only, then reset values.
    t = cyc;
    for (int unsigned i = 0; i < 6; i++) push_sweep(t + 1 + i, i);
    invalidate_i = 1'b1;
    step();
    invalidate_i = 1'b0;
    while (cyc < t + 7) step();
    reset_i = 1'b1;
    #1;
    check("reset_mid_sweep", 128'({wr_en_o, lookup_en_o, busy_o, drop_o}), 128'(4'b0100));
    step();
    reset_i = 1'b0;
    step();
    check("after_reset", 128'({wr_en_o, lookup_en_o, busy_o}), 128'(3'b010));
    repeat (4) step();

    check("writes_outstanding", 128'(exp_q.size()), 128'(0));
    check("drops_outstanding", 128'(exp_drop_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
